cmd_dispatch_ctrl: RTL

CMD_DISPATCH_CTRL -- requirements
Module: cmd_dispatch_ctrl

---
 rtl/cmd_dispatch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cmd_dispatch_ctrl.sv
// Command dispatcher: buffers 20-bit command words from the UART receiver and
// replays WRITE/READ commands onto a register bus, returning one response each.
module cmd_dispatch_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [19:0] cmd_data,
  output logic        rx_en,
  output logic        bus_req,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  typedef enum logic [1:0] {IDLE, DECODE, REQ, RESP} state_t;

  state_t         state, state_nxt;
  logic [19:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [19:0]    cmd_q;
  logic [7:0]     timer_q;
  logic           push, drop, pop, fifo_empty;
  logic           illegal_err, timeout_err, ack_hit;
  logic [1:0]     err_inc;
  logic [8:0]     err_sum;
  logic           in_req;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && (count <  CW'(FIFO_DEPTH));
  assign drop       = cmd_valid && (count == CW'(FIFO_DEPTH));
  assign rx_en      = (count <= CW'(FIFO_DEPTH - 2));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    illegal_err = 1'b0;
    timeout_err = 1'b0;
    ack_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        case (cmd_q[19:16])
          OP_WRITE, OP_READ: state_nxt = REQ;
          OP_NOP:            state_nxt = IDLE;
          default: begin
            illegal_err = 1'b1;
            state_nxt   = IDLE;
          end
        endcase
      end
      REQ: begin
        // An ack on the last allowed cycle takes priority over the timeout.
        if (bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = RESP;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the storage array has no reset; pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      timer_q <= '0;
    end else begin
      if (pop) cmd_q <= fifo_mem[rd_ptr];
      if (state == DECODE)   timer_q <= '0;
      else if (state == REQ) timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (ack_hit) begin
      rsp_data <= {cmd_q[15:8], (cmd_q[19:16] == OP_READ) ? bus_rdata : cmd_q[7:0]};
      rsp_err  <= 1'b0;
    end else if (timeout_err) begin
      rsp_data <= {cmd_q[15:8], 8'h00};
      rsp_err  <= 1'b1;
    end
  end

  // A drop can coincide with an illegal decode or a timeout, so up to two errors per cycle.
  assign err_inc = 2'(drop) + 2'(illegal_err) + 2'(timeout_err);
  assign err_sum = {1'b0, err_cnt} + 9'(err_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_cnt <= '0;
    else if (err_sum[8]) err_cnt <= 8'hFF;
    else                 err_cnt <= err_sum[7:0];
  end

  assign in_req    = (state == REQ);
  assign bus_req   = in_req;
  assign bus_we    = in_req && (cmd_q[19:16] == OP_WRITE);
  assign bus_addr  = in_req ? cmd_q[15:8] : 8'h00;
  assign bus_wdata = in_req ? cmd_q[7:0]  : 8'h00;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !fifo_empty;

endmodule
